// File: rtl/up_down_mod_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : up_down_counter_pkg
//  Brief    : Shared types for the up/down modulo counter (count modes and
//             FSM states).
//  Revision : 1.0 - initial release
// ============================================================================
package up_down_counter_pkg;

   // Count behaviour once the terminal value is reached; 2'b11 is reserved
   // and treated as MODE_WRAP by the counter.
   typedef enum logic [1:0] {
      MODE_WRAP    = 2'b00,
      MODE_SAT     = 2'b01,
      MODE_ONESHOT = 2'b10
   } mode_e;

   // COUNT: normal operation; HALT: frozen after a one-shot terminal.
   typedef enum logic {
      ST_COUNT = 1'b0,
      ST_HALT  = 1'b1
   } state_e;

endpackage : up_down_counter_pkg
`default_nettype wire

// File: rtl/up_down_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : up_down_mod_counter
//  Brief    : N-bit up/down counter with programmable terminal value, wrap /
//             saturate / one-shot modes and an active-low cascade chain.
//  Revision : 1.0 - initial release
// ============================================================================
module up_down_mod_counter
   import up_down_counter_pkg::*;
#(
   parameter int          N       = 8,
   parameter logic [N-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         en_b,
   input  logic         cin_b,
   input  logic         clr_b,
   input  logic         load_b,
   input  logic         up,
   input  logic [1:0]   mode,
   input  logic [N-1:0] limit,
   input  logic [N-1:0] load_in,
   output logic [N-1:0] q,
   output logic         tc_b,
   output logic         done,
   output logic         halted
);

   state_e state;
   logic   at_term;
   logic   count_ok;

   // Terminal detection: up-count uses >= so a loaded value above limit is
   // still treated as terminal; down-count terminates at zero.
   always_comb begin
      at_term  = up ? (q >= limit) : (q == '0);
      count_ok = !en_b && !cin_b && (state == ST_COUNT);
   end

   // Cascade output ignores en_b and state so a chain ripples purely on value.
   assign tc_b = ~(at_term && !cin_b);

   // Counter value, FSM and registered status flags; clear beats load beats count.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         q      <= RST_VAL;
         state  <= ST_COUNT;
         done   <= 1'b0;
         halted <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!clr_b) begin
            q      <= RST_VAL;
            state  <= ST_COUNT;
            halted <= 1'b0;
         end else if (!load_b) begin
            q      <= load_in;
            state  <= ST_COUNT;
            halted <= 1'b0;
         end else if (count_ok) begin
            if (!at_term) begin
               q <= up ? (q + 1'b1) : (q - 1'b1);
            end else begin
               case (mode)
                  MODE_SAT: begin
                     // Up also pulls an over-limit loaded value back to limit.
                     q <= up ? limit : '0;
                  end
                  MODE_ONESHOT: begin
                     state  <= ST_HALT;
                     halted <= 1'b1;
                     done   <= 1'b1;
                  end
                  default: begin
                     // MODE_WRAP and the reserved encoding.
                     q <= up ? '0 : limit;
                  end
               endcase
            end
         end
      end
   end

endmodule : up_down_mod_counter
`default_nettype wire

// File: tb/tb_up_down_mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_up_down_mod_counter
//  Brief    : Self-checking bench for up_down_mod_counter against a
//             behavioural model, plus a two-stage 4-bit cascade.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_up_down_mod_counter;

   localparam logic [7:0] RV = 8'h03;

   logic       clk = 1'b0;
   logic       rst_b, en_b, cin_b, clr_b, load_b, up;
   logic [1:0] mode;
   logic [7:0] limit, load_in, q;
   logic       tc_b, done, halted;

   // cascade stimulus / observation
   logic       c_en_b, c_clr_b;
   logic [3:0] lo_q, hi_q;
   logic       lo_tc_b, hi_tc_b, lo_done, hi_done, lo_halted, hi_halted;

   int checks   = 0;
   int failures = 0;

   // behavioural model state
   int m_q;
   bit m_halted, m_done;

   always #5 clk = ~clk;

   up_down_mod_counter #(.N(8), .RST_VAL(RV)) dut (
      .clk(clk), .rst_b(rst_b), .en_b(en_b), .cin_b(cin_b), .clr_b(clr_b),
      .load_b(load_b), .up(up), .mode(mode), .limit(limit), .load_in(load_in),
      .q(q), .tc_b(tc_b), .done(done), .halted(halted)
   );

   up_down_mod_counter #(.N(4), .RST_VAL(4'h0)) lo_stage (
      .clk(clk), .rst_b(rst_b), .en_b(c_en_b), .cin_b(1'b0), .clr_b(c_clr_b),
      .load_b(1'b1), .up(1'b1), .mode(2'b00), .limit(4'hF), .load_in(4'h0),
      .q(lo_q), .tc_b(lo_tc_b), .done(lo_done), .halted(lo_halted)
   );

   up_down_mod_counter #(.N(4), .RST_VAL(4'h0)) hi_stage (
      .clk(clk), .rst_b(rst_b), .en_b(c_en_b), .cin_b(lo_tc_b), .clr_b(c_clr_b),
      .load_b(1'b1), .up(1'b1), .mode(2'b00), .limit(4'hF), .load_in(4'h0),
      .q(hi_q), .tc_b(hi_tc_b), .done(hi_done), .halted(hi_halted)
   );

   // Reference: the rules applied to plain integers at one clock edge.
   function automatic bit model_at_term();
      return up ? (m_q >= int'(limit)) : (m_q == 0);
   endfunction

   function automatic void model_edge();
      m_done = 1'b0;
      if (!rst_b) begin
         m_q = int'(RV); m_halted = 1'b0;
      end else if (!clr_b) begin
         m_q = int'(RV); m_halted = 1'b0;
      end else if (!load_b) begin
         m_q = int'(load_in); m_halted = 1'b0;
      end else if (!en_b && !cin_b && !m_halted) begin
         if (!model_at_term()) begin
            m_q = up ? m_q + 1 : m_q - 1;
         end else if (mode == 2'd1) begin
            m_q = up ? int'(limit) : 0;
         end else if (mode == 2'd2) begin
            m_halted = 1'b1; m_done = 1'b1;
         end else begin
            m_q = up ? 0 : int'(limit);
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_load(input logic [7:0] v);
      load_in = v; load_b = 1'b0;
      tick();
      load_b = 1'b1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; en_b = 1'b1; cin_b = 1'b0; clr_b = 1'b1; load_b = 1'b1;
      up = 1'b1; mode = 2'd0; limit = 8'd9; load_in = 8'd0;
      c_en_b = 1'b1; c_clr_b = 1'b1;
      m_q = int'(RV); m_halted = 1'b0; m_done = 1'b0;
      #12;
      checks++;
      if (q !== RV || done !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_init: q=%0d done=%b halted=%b required q=%0d done=0 halted=0", q, done, halted, RV);
      end
      rst_b = 1'b1;
      do_load(8'd4);
      en_b = 1'b0;
      tick();
      checks++;
      if (q !== 8'd5) begin
         failures++; $display("FAIL reset_precount: q=%0d required 5", q);
      end
      #2 rst_b = 1'b0;
      m_q = int'(RV); m_halted = 1'b0; m_done = 1'b0;
      #1;
      checks++;
      if (q !== RV || done !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL reset_async: q=%0d done=%b halted=%b required q=%0d done=0 halted=0", q, done, halted, RV);
      end
      tick();
      rst_b = 1'b1;
      tick();
      checks++;
      if (q !== RV + 8'd1) begin
         failures++; $display("FAIL reset_resume: q=%0d required %0d", q, RV + 8'd1);
      end
   endtask

   task automatic test_wrap();
      mode = 2'd0; limit = 8'd9; up = 1'b1; en_b = 1'b1;
      do_load(8'd0);
      en_b = 1'b0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (tc_b !== !(model_at_term() && !cin_b)) begin
            failures++; $display("FAIL wrap_tc step%0d: tc_b=%b at q=%0d", i, tc_b, q);
         end
         tick();
         checks++;
         if (int'(q) !== m_q) begin
            failures++; $display("FAIL wrap_up step%0d: q=%0d required %0d", i, q, m_q);
         end
      end
      en_b = 1'b1;
      do_load(8'd0);
      up = 1'b0; en_b = 1'b0;
      tick();
      checks++;
      if (q !== 8'd9) begin
         failures++; $display("FAIL wrap_down: q=%0d required 9", q);
      end
      en_b = 1'b1;
   endtask

   task automatic test_sat();
      mode = 2'd1; limit = 8'd3; up = 1'b1;
      do_load(8'd0);
      en_b = 1'b0;
      repeat (6) tick();
      checks++;
      if (q !== 8'd3 || tc_b !== 1'b0) begin
         failures++; $display("FAIL sat_up: q=%0d tc_b=%b required q=3 tc_b=0", q, tc_b);
      end
      en_b = 1'b1;
      do_load(8'd1);
      up = 1'b0; en_b = 1'b0;
      repeat (3) tick();
      checks++;
      if (q !== 8'd0) begin
         failures++; $display("FAIL sat_down: q=%0d required 0", q);
      end
      en_b = 1'b1;
      do_load(8'd200);
      checks++;
      if (q !== 8'd200) begin
         failures++; $display("FAIL sat_overload: q=%0d required 200", q);
      end
      up = 1'b1; en_b = 1'b0;
      tick();
      checks++;
      if (q !== 8'd3) begin
         failures++; $display("FAIL sat_pull: q=%0d required 3", q);
      end
      en_b = 1'b1;
   endtask

   task automatic test_oneshot();
      int pulses = 0;
      mode = 2'd2; limit = 8'd9; up = 1'b0;
      do_load(8'd4);
      en_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (done === 1'b1) pulses++;
         checks++;
         if (int'(q) !== m_q || done !== m_done || halted !== m_halted) begin
            failures++;
            $display("FAIL oneshot step%0d: q=%0d done=%b halted=%b required q=%0d done=%b halted=%b",
                     i, q, done, halted, m_q, m_done, m_halted);
         end
      end
      checks++;
      if (pulses != 1 || halted !== 1'b1 || q !== 8'd0) begin
         failures++; $display("FAIL oneshot_final: pulses=%0d halted=%b q=%0d required 1,1,0", pulses, halted, q);
      end
      do_load(8'd7);
      checks++;
      if (q !== 8'd7 || halted !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL oneshot_reload: q=%0d halted=%b done=%b required 7,0,0", q, halted, done);
      end
      tick();
      checks++;
      if (q !== 8'd6) begin
         failures++; $display("FAIL oneshot_resume: q=%0d required 6", q);
      end
      en_b = 1'b1;
   endtask

   task automatic test_priority();
      en_b = 1'b1; load_in = 8'd77; clr_b = 1'b0; load_b = 1'b0;
      tick();
      clr_b = 1'b1; load_b = 1'b1;
      checks++;
      if (q !== RV) begin
         failures++; $display("FAIL prio_clr_over_load: q=%0d required %0d", q, RV);
      end
      do_load(8'd55);
      checks++;
      if (q !== 8'd55) begin
         failures++; $display("FAIL prio_load_disabled: q=%0d required 55", q);
      end
   endtask

   task automatic test_limit_zero();
      limit = 8'd0; up = 1'b1; mode = 2'd3;
      do_load(8'd0);
      en_b = 1'b0;
      repeat (3) tick();
      checks++;
      if (q !== 8'd0 || tc_b !== 1'b0) begin
         failures++; $display("FAIL lim0_wrap: q=%0d tc_b=%b required 0,0", q, tc_b);
      end
      mode = 2'd2;
      tick();
      checks++;
      if (q !== 8'd0 || done !== 1'b1 || halted !== 1'b1) begin
         failures++; $display("FAIL lim0_oneshot: q=%0d done=%b halted=%b required 0,1,1", q, done, halted);
      end
      en_b = 1'b1; clr_b = 1'b0;
      tick();
      clr_b = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en_b    = ($urandom_range(0, 9) == 0);
         cin_b   = ($urandom_range(0, 7) == 0);
         clr_b   = ($urandom_range(0, 39) != 0);
         load_b  = ($urandom_range(0, 19) != 0);
         up      = $urandom_range(0, 1);
         mode    = 2'($urandom_range(0, 3));
         limit   = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 20));
         load_in = 8'($urandom_range(0, 255));
         #1;
         checks++;
         if (tc_b !== !(model_at_term() && !cin_b)) begin
            failures++; $display("FAIL rand_tc cyc%0d: tc_b=%b q=%0d", i, tc_b, q);
         end
         tick();
         checks++;
         if (int'(q) !== m_q || done !== m_done || halted !== m_halted) begin
            failures++;
            $display("FAIL rand_state cyc%0d: q=%0d done=%b halted=%b required q=%0d done=%b halted=%b",
                     i, q, done, halted, m_q, m_done, m_halted);
         end
      end
      en_b = 1'b1; cin_b = 1'b0; clr_b = 1'b1; load_b = 1'b1;
   endtask

   task automatic test_cascade();
      int c = 0;
      c_clr_b = 1'b0;
      tick();
      c_clr_b = 1'b1; c_en_b = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         c = (c + 1) % 256;
         checks++;
         if ({hi_q, lo_q} !== 8'(c)) begin
            failures++; $display("FAIL cascade cyc%0d: {hi,lo}=%0d required %0d", i, {hi_q, lo_q}, c);
         end
      end
      c_en_b = 1'b1;
      checks++;
      if ({hi_q, lo_q} !== 8'd44) begin
         failures++; $display("FAIL cascade_final: {hi,lo}=%0d required 44", {hi_q, lo_q});
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_sat();
      test_oneshot();
      test_priority();
      test_limit_zero();
      test_random();
      test_cascade();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_up_down_mod_counter
`default_nettype wire
